spi_target_regfile: RTL and testbench
=====================================

// Module: spi_target_regfile
// PURPOSE
// - SPI target (slave) end of the CPU's SPI link: receives frames driven by the CPU-side SPI master
//   regfile, writes/reads a local bank of N_REGS x W_DATA registers, returns read data on miso.
// - Sits in the peripheral domain; SPI pins are oversampled by the system clock; no second clock.
// - Local logic reads the bank via a combinational read port and sees each SPI write as a one-cycle strobe.
// PARAMETERS
// - W_DATA      32  data bits per frame and register width
// - N_REGS       8  registers in bank; address width W_ADDR = $clog2(N_REGS)
// - SYNC_STAGES  2  flops in each sclk/cs_n/mosi synchronizer (>=2)
// PORTS
// - clk        in   1       system clock; all state on posedge clk
// - rst        in   1       asynchronous, active-low reset
// - sclk       in   1       SPI clock from master, mode 0 (CPOL=0, CPHA=0)
// - cs_n       in   1       SPI chip select, active low
// - mosi       in   1       SPI data master->target, MSB first
// - miso       out  1       SPI data target->master, MSB first
// - miso_oe    out  1       1 while cs_n (synced) low; tri-state enable for pad
// - wr_valid   out  1       one-cycle pulse: register wr_addr just updated with wr_data
// - wr_addr    out  W_ADDR  address of last SPI write
// - wr_data    out  W_DATA  data of last SPI write
// - frame_err  out  1       one-cycle pulse: frame aborted (cs_n high after 1..39 bits)
// - loc_ra     in   W_ADDR  local read address
// - loc_rd     out  W_DATA  bank[loc_ra], combinational
// BEHAVIOUR
// - Reset (rst=0, any time incl. mid-frame): state=IDLE, bit_cnt=0, all registers=0, miso=0,
//   miso_oe=0, wr_valid=0, frame_err=0, wr_addr=0, wr_data=0. Synchronizers reset to cs_n=1, sclk=0.
// - Inputs pass SYNC_STAGES flops; rise/fall = edge detect on synced sclk. clk must be >= 8x sclk.
// - Frame = 8-bit command + W_DATA data bits (40 at default). cmd[7]=1 write, 0 read; cmd[6:0] address.
//   Address >= N_REGS: write discarded (no wr_valid), read returns 0.
// - mosi sampled on sclk rise; miso updated on sclk fall; miso=0 outside read data phase.
// - FSM (6-bit bit_cnt counts sampled rises in current frame):
//   IDLE  : cs_n falls -> CMD, bit_cnt=0.
//   CMD   : shift mosi on each rise; on 8th rise: write -> WDATA; read -> RDATA, snapshot bank[addr]
//           (or 0) into tx shift reg; bit W_DATA-1 driven on following fall.
//   WDATA : shift mosi on each rise; on last (40th) rise -> DONE; next clk: bank[addr]<=data,
//           wr_valid=1 for one cycle, wr_addr/wr_data updated (hold until next write).
//   RDATA : each fall shifts tx reg, miso = next bit; on 40th rise -> DONE.
//   DONE  : ignore further sclk edges, miso=0; cs_n high -> IDLE.
// - cs_n high in CMD/WDATA/RDATA (1..39 bits taken) -> IDLE, frame_err pulse, no write.
//   cs_n high with bit_cnt=0 -> IDLE, no error.
// - Read snapshot fixed at command completion; a simultaneous local/SPI write does not alter it.
// - Read-after-write across frames: new value visible to next frame and to loc_rd 1 clk after wr_valid.
// - sclk edges while cs_n high are ignored.
// STRUCTURE
// - Shared defines file spi_defs.v: SPI_W_CMD=8, CMD_RW_BIT=7, CMD_ADDR field, CMD_WRITE/CMD_READ
//   values, FSM state encodings (IDLE/CMD/WDATA/RDATA/DONE); shared with master-side SPI regfile.
// - One sub-module spi_sync_edge: SYNC_STAGES synchronizer + rise/fall pulses; instantiated
//   for sclk (with edges), cs_n and mosi (level only).
// - Top holds FSM, bit counter, rx/tx shift registers, register bank, read mux.
// TESTING
// - Write 0xDEADBEEF to addr 3 (cmd 0x83) -> one wr_valid, wr_addr=3, wr_data=0xDEADBEEF, loc_rd(3)=0xDEADBEEF.
// - Then read addr 3 (cmd 0x03) -> miso carries 0xDEADBEEF MSB first across 32 rises; miso_oe high throughout.
// - Write frame with cs_n raised after 20 bits -> frame_err pulse, no wr_valid, reg unchanged; next frame OK.
// - Write 0x12345678 to addr 9 -> no wr_valid, bank unchanged; read addr 9 -> miso all 0.
// - rst low mid-read after 15 bits -> miso=0, miso_oe=0, bank cleared; following write+read of 0x0000A5A5 correct.
// - Two back-to-back frames (cs_n high one sclk period), 45 sclk in first -> extras ignored, both frames correct.

Source files
------------

// File: rtl/spi_target_regfile_pkg.sv
// Shared SPI frame definitions: command layout, FSM encodings and command decode helpers.
// The CPU-side SPI master regfile uses the same values, so the two ends of the link agree on framing.
package spi_target_regfile_pkg;

  localparam int W_CMD        = 8;
  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;
  localparam int CMD_ADDR_LSB = 0;
  localparam int W_CMD_ADDR   = CMD_ADDR_MSB - CMD_ADDR_LSB + 1;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_RDATA = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic                  rw;
    logic [W_CMD_ADDR-1:0] addr;
  } cmd_t;

  function automatic cmd_t decodeCmd(input logic [W_CMD-1:0] raw);
    cmd_t c;
    c.rw   = raw[CMD_RW_BIT];
    c.addr = raw[CMD_ADDR_MSB:CMD_ADDR_LSB];
    return c;
  endfunction

  // The command carries a 7-bit address but the bank is usually smaller.
  function automatic logic addrInRange(input logic [W_CMD_ADDR-1:0] addr, input int nRegs);
    return int'(addr) < nRegs;
  endfunction

endpackage

// File: rtl/spi_target_regfile_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses on the synced level.
// The reset value lets cs_n come out of reset deasserted (high) and sclk idle (low).
module spi_target_regfile_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_target_regfile.sv
// SPI mode-0 target with a local register bank: 8-bit command then W_DATA data bits per frame.
// Pins are oversampled by clk_i; writes appear locally as a one-cycle wr_valid_o strobe.
module spi_target_regfile
  import spi_target_regfile_pkg::*;
#(
  parameter int W_DATA      = 32,
  parameter int N_REGS      = 8,
  parameter int SYNC_STAGES = 2,
  localparam int W_ADDR     = $clog2(N_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic              wr_valid_o,
  output logic [W_ADDR-1:0] wr_addr_o,
  output logic [W_DATA-1:0] wr_data_o,
  output logic              frame_err_o,
  input  logic [W_ADDR-1:0] loc_ra_i,
  output logic [W_DATA-1:0] loc_rd_o
);

  localparam int         FRAME_BITS = W_CMD + W_DATA;
  localparam logic [5:0] CMD_LAST   = 6'(W_CMD - 1);
  localparam logic [5:0] FRAME_LAST = 6'(FRAME_BITS - 1);

  logic sclkRise, sclkFall, csSync, mosiSync;
  logic unusedSclkLevel, unusedCsRise, unusedCsFall, unusedMosiRise, unusedMosiFall;

  spi_target_regfile_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (sclk_i),
    .q_o    (unusedSclkLevel),
    .rise_o (sclkRise),
    .fall_o (sclkFall)
  );

  spi_target_regfile_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (cs_n_i),
    .q_o    (csSync),
    .rise_o (unusedCsRise),
    .fall_o (unusedCsFall)
  );

  spi_target_regfile_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (mosi_i),
    .q_o    (mosiSync),
    .rise_o (unusedMosiRise),
    .fall_o (unusedMosiFall)
  );

  logic [2:0]        state_q, stateD;
  logic [5:0]        bitCnt_q, bitCntD;
  logic [W_CMD-1:0]  cmd_q, cmdD;
  logic [W_DATA-1:0] rx_q, rxD;
  logic [W_DATA-1:0] tx_q, txD;
  logic              miso_q, misoD;
  logic              frameErr_q, frameErrD;
  logic              wrValid_q;
  logic [W_ADDR-1:0] wrAddr_q;
  logic [W_DATA-1:0] wrData_q;
  logic [W_DATA-1:0] bank_q [N_REGS];

  logic              wrCommit;
  logic [W_ADDR-1:0] wrIdx;
  cmd_t              cmdNext;
  logic [W_DATA-1:0] snapshot;

  // cmdNext is the command as it will look once the current mosi bit is shifted in.
  assign cmdNext  = decodeCmd({cmd_q[W_CMD-2:0], mosiSync});
  assign snapshot = addrInRange(cmdNext.addr, N_REGS) ? bank_q[cmdNext.addr[W_ADDR-1:0]] : '0;
  assign wrIdx    = cmd_q[W_ADDR-1:0];

  always_comb begin
    stateD    = state_q;
    bitCntD   = bitCnt_q;
    cmdD      = cmd_q;
    rxD       = rx_q;
    txD       = tx_q;
    misoD     = miso_q;
    frameErrD = 1'b0;
    wrCommit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        misoD = 1'b0;
        if (!csSync) begin
          stateD  = ST_CMD;
          bitCntD = '0;
        end
      end
      ST_CMD: begin
        if (csSync) begin
          stateD    = ST_IDLE;
          frameErrD = (bitCnt_q != '0);
          bitCntD   = '0;
        end else if (sclkRise) begin
          cmdD    = {cmd_q[W_CMD-2:0], mosiSync};
          bitCntD = bitCnt_q + 6'd1;
          if (bitCnt_q == CMD_LAST) begin
            if (cmdNext.rw == CMD_WRITE) begin
              stateD = ST_WDATA;
            end else if (cmdNext.rw == CMD_READ) begin
              stateD = ST_RDATA;
              txD    = snapshot;
            end
          end
        end
      end
      ST_WDATA: begin
        if (csSync) begin
          stateD    = ST_IDLE;
          frameErrD = 1'b1;
          bitCntD   = '0;
        end else if (sclkRise) begin
          rxD     = {rx_q[W_DATA-2:0], mosiSync};
          bitCntD = bitCnt_q + 6'd1;
          if (bitCnt_q == FRAME_LAST) begin
            stateD   = ST_DONE;
            wrCommit = addrInRange(cmd_q[CMD_ADDR_MSB:CMD_ADDR_LSB], N_REGS);
          end
        end
      end
      ST_RDATA: begin
        if (csSync) begin
          stateD    = ST_IDLE;
          frameErrD = 1'b1;
          bitCntD   = '0;
          misoD     = 1'b0;
        end else begin
          if (sclkFall) begin
            misoD = tx_q[W_DATA-1];
            txD   = {tx_q[W_DATA-2:0], 1'b0};
          end
          if (sclkRise) begin
            bitCntD = bitCnt_q + 6'd1;
            if (bitCnt_q == FRAME_LAST) begin
              stateD = ST_DONE;
              misoD  = 1'b0;
            end
          end
        end
      end
      ST_DONE: begin
        misoD = 1'b0;
        if (csSync) begin
          stateD  = ST_IDLE;
          bitCntD = '0;
        end
      end
      default: begin
        stateD  = ST_IDLE;
        bitCntD = '0;
        misoD   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      bitCnt_q   <= '0;
      cmd_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= stateD;
      bitCnt_q   <= bitCntD;
      cmd_q      <= cmdD;
      rx_q       <= rxD;
      tx_q       <= txD;
      miso_q     <= misoD;
      frameErr_q <= frameErrD;
    end
  end

  // The bank update and the wr_valid strobe land on the same edge, so local logic
  // sampling loc_rd on the strobe cycle already sees the new value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrValid_q <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      for (int i = 0; i < N_REGS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      wrValid_q <= wrCommit;
      if (wrCommit) begin
        bank_q[wrIdx] <= rxD;
        wrAddr_q      <= wrIdx;
        wrData_q      <= rxD;
      end
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe_o   = ~csSync;
  assign wr_valid_o  = wrValid_q;
  assign wr_addr_o   = wrAddr_q;
  assign wr_data_o   = wrData_q;
  assign frame_err_o = frameErr_q;
  assign loc_rd_o    = bank_q[loc_ra_i];

endmodule

// File: tb/tb_spi_target_regfile.sv
// Directed bench for spi_target_regfile: a table of SPI frames with hand-computed results,
// followed by the reset-mid-read and back-to-back-frame sequences.
module tb_spi_target_regfile;

  localparam int HALF = 80;
  localparam int NV   = 12;

  logic        clk = 1'b0;
  logic        rstN;
  logic        sclk;
  logic        csN;
  logic        mosi;
  logic        miso;
  logic        misoOe;
  logic        wrValid;
  logic [2:0]  wrAddr;
  logic [31:0] wrData;
  logic        frameErr;
  logic [2:0]  locRa;
  logic [31:0] locRd;

  int checks = 0;
  int errors = 0;
  int wrPulses = 0;
  int errPulses = 0;

  spi_target_regfile #(.W_DATA(32), .N_REGS(8), .SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .sclk_i      (sclk),
    .cs_n_i      (csN),
    .mosi_i      (mosi),
    .miso_o      (miso),
    .miso_oe_o   (misoOe),
    .wr_valid_o  (wrValid),
    .wr_addr_o   (wrAddr),
    .wr_data_o   (wrData),
    .frame_err_o (frameErr),
    .loc_ra_i    (locRa),
    .loc_rd_o    (locRd)
  );

  always #5 clk = ~clk;

  // Pulses are counted per clock so a strobe held longer than one cycle shows up as an extra count.
  always @(negedge clk) begin
    if (wrValid) wrPulses++;
    if (frameErr) errPulses++;
  end

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [31:0] data;
    int          nBits;
    int          expWr;
    int          expErr;
    bit          isRead;
    logic [31:0] expRead;
    logic [2:0]  locAddr;
    logic [31:0] locExp;
  } vec_t;

  vec_t        vecs [NV];
  logic [63:0] rx;
  int          oeLow;
  int          wrBefore;
  int          errBefore;
  logic [2:0]  lastAddr;
  logic [31:0] lastData;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One master-side frame: mosi changes while sclk is low, miso is sampled just before each rise.
  task automatic applyStimulus(input logic [63:0] txBits, input int nBits, input int gapNs,
                               output logic [63:0] rxBits, output int oeLowCnt);
    rxBits   = '0;
    oeLowCnt = 0;
    csN = 1'b0;
    #(HALF);
    for (int i = 0; i < nBits; i++) begin
      mosi = txBits[63-i];
      #(HALF);
      rxBits[63-i] = miso;
      if (!misoOe) oeLowCnt++;
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
    #(HALF);
    csN  = 1'b1;
    mosi = 1'b0;
    #(gapNs);
  endtask

  initial begin
    vecs[0]  = '{"wr3",      8'h83, 32'hDEADBEEF, 40, 1, 0, 1'b0, 32'h0,        3'd3, 32'hDEADBEEF};
    vecs[1]  = '{"rd3",      8'h03, 32'h0,        40, 0, 0, 1'b1, 32'hDEADBEEF, 3'd3, 32'hDEADBEEF};
    vecs[2]  = '{"abort20",  8'h83, 32'h11111111, 20, 0, 1, 1'b0, 32'h0,        3'd3, 32'hDEADBEEF};
    vecs[3]  = '{"rd3after", 8'h03, 32'h0,        40, 0, 0, 1'b1, 32'hDEADBEEF, 3'd3, 32'hDEADBEEF};
    vecs[4]  = '{"wr9",      8'h89, 32'h12345678, 40, 0, 0, 1'b0, 32'h0,        3'd1, 32'h0};
    vecs[5]  = '{"rd9",      8'h09, 32'h0,        40, 0, 0, 1'b1, 32'h0,        3'd1, 32'h0};
    vecs[6]  = '{"wr5",      8'h85, 32'hCAFEF00D, 40, 1, 0, 1'b0, 32'h0,        3'd5, 32'hCAFEF00D};
    vecs[7]  = '{"rd5",      8'h05, 32'h0,        40, 0, 0, 1'b1, 32'hCAFEF00D, 3'd5, 32'hCAFEF00D};
    vecs[8]  = '{"wr0",      8'h80, 32'h00000001, 40, 1, 0, 1'b0, 32'h0,        3'd0, 32'h00000001};
    vecs[9]  = '{"wr7",      8'h87, 32'h80000000, 40, 1, 0, 1'b0, 32'h0,        3'd7, 32'h80000000};
    vecs[10] = '{"rd7",      8'h07, 32'h0,        40, 0, 0, 1'b1, 32'h80000000, 3'd7, 32'h80000000};
    vecs[11] = '{"abortCmd", 8'h85, 32'h0,         4, 0, 1, 1'b0, 32'h0,        3'd5, 32'hCAFEF00D};

    rstN  = 1'b0;
    sclk  = 1'b0;
    csN   = 1'b1;
    mosi  = 1'b0;
    locRa = 3'd0;
    lastAddr = 3'd0;
    lastData = 32'h0;
    #53;
    rstN = 1'b1;
    #100;

    checkOutput("reset miso", 64'(miso), 64'h0);
    checkOutput("reset miso_oe", 64'(misoOe), 64'h0);
    checkOutput("reset wr_valid", 64'(wrPulses), 64'h0);
    checkOutput("reset frame_err", 64'(errPulses), 64'h0);
    checkOutput("reset wr_addr", 64'(wrAddr), 64'h0);
    checkOutput("reset wr_data", 64'(wrData), 64'h0);
    for (int r = 0; r < 8; r++) begin
      locRa = 3'(r);
      #10;
      checkOutput($sformatf("reset loc_rd[%0d]", r), 64'(locRd), 64'h0);
    end

    for (int v = 0; v < NV; v++) begin
      wrBefore  = wrPulses;
      errBefore = errPulses;
      applyStimulus({vecs[v].cmd, vecs[v].data, 24'h0}, vecs[v].nBits, 200, rx, oeLow);
      checkOutput({vecs[v].name, " wr_valid pulses"}, 64'(wrPulses - wrBefore), 64'(vecs[v].expWr));
      checkOutput({vecs[v].name, " frame_err pulses"}, 64'(errPulses - errBefore), 64'(vecs[v].expErr));
      if (vecs[v].expWr != 0) begin
        lastAddr = vecs[v].cmd[2:0];
        lastData = vecs[v].data;
      end
      checkOutput({vecs[v].name, " wr_addr"}, 64'(wrAddr), 64'(lastAddr));
      checkOutput({vecs[v].name, " wr_data"}, 64'(wrData), 64'(lastData));
      if (vecs[v].isRead) begin
        checkOutput({vecs[v].name, " miso data"}, 64'(rx[55:24]), 64'(vecs[v].expRead));
        checkOutput({vecs[v].name, " miso in cmd phase"}, 64'(rx[63:56]), 64'h0);
        checkOutput({vecs[v].name, " miso_oe low samples"}, 64'(oeLow), 64'h0);
      end
      locRa = vecs[v].locAddr;
      #10;
      checkOutput({vecs[v].name, " loc_rd"}, 64'(locRd), 64'(vecs[v].locExp));
    end

    // Reset in the middle of a read of addr 3, then a fresh write/read must work.
    errBefore = errPulses;
    locRa = 3'd3;
    csN = 1'b0;
    #(HALF);
    for (int i = 0; i < 15; i++) begin
      mosi = (i == 6 || i == 7) ? 1'b1 : 1'b0;
      #(HALF);
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
    rstN = 1'b0;
    #20;
    checkOutput("midreset miso", 64'(miso), 64'h0);
    checkOutput("midreset miso_oe", 64'(misoOe), 64'h0);
    checkOutput("midreset loc_rd[3]", 64'(locRd), 64'h0);
    csN  = 1'b1;
    mosi = 1'b0;
    #20;
    rstN = 1'b1;
    #100;
    checkOutput("midreset frame_err pulses", 64'(errPulses - errBefore), 64'h0);
    locRa = 3'd5;
    #10;
    checkOutput("midreset bank cleared [5]", 64'(locRd), 64'h0);
    wrBefore = wrPulses;
    applyStimulus({8'h83, 32'h0000A5A5, 24'h0}, 40, 200, rx, oeLow);
    checkOutput("postreset wr_valid pulses", 64'(wrPulses - wrBefore), 64'h1);
    checkOutput("postreset wr_data", 64'(wrData), 64'h0000A5A5);
    applyStimulus({8'h03, 32'h0, 24'h0}, 40, 200, rx, oeLow);
    checkOutput("postreset miso data", 64'(rx[55:24]), 64'h0000A5A5);
    locRa = 3'd3;
    #10;
    checkOutput("postreset loc_rd[3]", 64'(locRd), 64'h0000A5A5);

    // Back-to-back frames: 45 clocks in the first (extras must be ignored), one-period gap.
    wrBefore  = wrPulses;
    errBefore = errPulses;
    applyStimulus({8'h82, 32'h0F0F1234, 24'hFFFFFF}, 45, 2 * HALF, rx, oeLow);
    applyStimulus({8'h02, 32'h0, 24'h0}, 40, 200, rx, oeLow);
    checkOutput("b2b wr_valid pulses", 64'(wrPulses - wrBefore), 64'h1);
    checkOutput("b2b frame_err pulses", 64'(errPulses - errBefore), 64'h0);
    checkOutput("b2b wr_addr", 64'(wrAddr), 64'h2);
    checkOutput("b2b wr_data", 64'(wrData), 64'h0F0F1234);
    checkOutput("b2b miso data", 64'(rx[55:24]), 64'h0F0F1234);
    checkOutput("b2b miso_oe low samples", 64'(oeLow), 64'h0);
    locRa = 3'd2;
    #10;
    checkOutput("b2b loc_rd[2]", 64'(locRd), 64'h0F0F1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
